// File: rtl/column_drawer.sv
// Column rasteriser for the raycaster: one pixel per clock, top to bottom.
// Each column is ceiling, then a centred wall slice, then floor.
module column_drawer #(
  parameter int SCREEN_W     = 160,
  parameter int SCREEN_H     = 120,
  parameter int X_WIDTH      = 8,
  parameter int Y_WIDTH      = 7,
  parameter int COLOUR_WIDTH = 3
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [X_WIDTH-1:0]      req_x,
  input  logic [Y_WIDTH-1:0]      req_height,
  input  logic [COLOUR_WIDTH-1:0] req_wall,
  input  logic [COLOUR_WIDTH-1:0] req_ceil,
  input  logic [COLOUR_WIDTH-1:0] req_floor,
  output logic [X_WIDTH-1:0]      vga_x,
  output logic [Y_WIDTH-1:0]      vga_y,
  output logic [COLOUR_WIDTH-1:0] vga_colour,
  output logic                    vga_write,
  output logic                    done
);

  localparam logic [Y_WIDTH-1:0] H    = Y_WIDTH'(SCREEN_H);
  localparam logic [Y_WIDTH-1:0] LAST = Y_WIDTH'(SCREEN_H - 1);
  localparam logic [X_WIDTH-1:0] W    = X_WIDTH'(SCREEN_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t                  state_q;
  logic                    ready_q;
  logic                    on_q;
  logic [X_WIDTH-1:0]      x_q;
  logic [Y_WIDTH-1:0]      y_q;
  logic [Y_WIDTH-1:0]      top_q;
  logic [Y_WIDTH-1:0]      bot_q;
  logic [COLOUR_WIDTH-1:0] wall_q;
  logic [COLOUR_WIDTH-1:0] ceil_q;
  logic [COLOUR_WIDTH-1:0] floor_q;

  logic [Y_WIDTH-1:0]      h_d;
  logic [Y_WIDTH-1:0]      top_d;
  logic [Y_WIDTH-1:0]      bot_d;
  logic                    on_d;
  logic [COLOUR_WIDTH-1:0] first_d;
  logic [COLOUR_WIDTH-1:0] pix_d;

  assign req_ready = ready_q;

  // Row 0 is emitted on the accept edge, so its colour comes from req_*.
  always_comb begin
    h_d     = (req_height > H) ? H : req_height;
    top_d   = (H - h_d) >> 1;
    bot_d   = top_d + h_d;
    on_d    = req_x < W;
    first_d = (top_d != '0) ? req_ceil :
              (bot_d != '0) ? req_wall : req_floor;
    pix_d   = (y_q < top_q) ? ceil_q :
              (y_q < bot_q) ? wall_q : floor_q;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      ready_q    <= 1'b1;
      on_q       <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      top_q      <= '0;
      bot_q      <= '0;
      wall_q     <= '0;
      ceil_q     <= '0;
      floor_q    <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_write  <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!ready_q) begin
            ready_q <= 1'b1;
          end else if (req_valid) begin
            ready_q   <= 1'b0;
            on_q      <= on_d;
            x_q       <= req_x;
            top_q     <= top_d;
            bot_q     <= bot_d;
            wall_q    <= req_wall;
            ceil_q    <= req_ceil;
            floor_q   <= req_floor;
            y_q       <= Y_WIDTH'(1);
            state_q   <= DRAW;
            vga_write <= on_d;
            if (on_d) begin
              vga_x      <= req_x;
              vga_y      <= '0;
              vga_colour <= first_d;
            end
          end
        end
        DRAW: begin
          vga_write <= on_q;
          if (on_q) begin
            vga_x      <= x_q;
            vga_y      <= y_q;
            vga_colour <= pix_d;
          end
          if (y_q == LAST) begin
            state_q <= FIN;
          end else begin
            y_q <= y_q + Y_WIDTH'(1);
          end
        end
        FIN: begin
          vga_write <= 1'b0;
          done      <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_column_drawer.sv
// Randomised bench for column_drawer against a row-rule model.
// Each scenario captures one column window and checks it inline.
module tb_column_drawer;

  logic       clock      = 1'b0;
  logic       resetn     = 1'b0;
  logic       req_valid  = 1'b0;
  logic       req_ready;
  logic [7:0] req_x      = '0;
  logic [6:0] req_height = '0;
  logic [2:0] req_wall   = '0;
  logic [2:0] req_ceil   = '0;
  logic [2:0] req_floor  = '0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_write;
  logic       done;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] h;
    logic [2:0] w;
    logic [2:0] c;
    logic [2:0] f;
  } req_t;

  req_t acc;
  int   acc_cyc;
  logic       o_wr [1:122];
  logic [7:0] o_x  [1:122];
  logic [6:0] o_y  [1:122];
  logic [2:0] o_c  [1:122];
  logic       o_dn [1:122];
  logic       o_rdy[1:122];

  column_drawer dut (
    .clock     (clock),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_height(req_height),
    .req_wall  (req_wall),
    .req_ceil  (req_ceil),
    .req_floor (req_floor),
    .vga_x     (vga_x),
    .vga_y     (vga_y),
    .vga_colour(vga_colour),
    .vga_write (vga_write),
    .done      (done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Centred slice: rows above = floor((120 - clamped h) / 2).
  function automatic logic [2:0] model(req_t r, int y);
    int h;
    int above;
    h = (int'(r.h) > 120) ? 120 : int'(r.h);
    above = (120 - h) / 2;
    if (y < above) return r.c;
    if (y < above + h) return r.w;
    return r.f;
  endfunction

  function automatic req_t rnd(bit any_x);
    req_t r;
    r.x = any_x ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 159));
    r.h = 7'($urandom_range(0, 127));
    r.w = 3'($urandom);
    r.c = 3'($urandom);
    r.f = 3'($urandom);
    return r;
  endfunction

  task automatic drive(req_t r);
    req_x      = r.x;
    req_height = r.h;
    req_wall   = r.w;
    req_ceil   = r.c;
    req_floor  = r.f;
  endtask

  // Called at a negedge; records 122 cycles after the accept edge.
  task automatic capture(input bit hold, input bit mutate);
    int n;
    n = 0;
    req_valid = 1'b1;
    while (req_ready !== 1'b1 && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (req_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_wait req_ready=%b required 1", req_ready);
    end
    acc = {req_x, req_height, req_wall, req_ceil, req_floor};
    @(posedge clock);
    #1;
    acc_cyc = cyc;
    if (!hold) req_valid = 1'b0;
    for (int k = 1; k <= 122; k++) begin
      @(negedge clock);
      o_wr[k]  = vga_write;
      o_x[k]   = vga_x;
      o_y[k]   = vga_y;
      o_c[k]   = vga_colour;
      o_dn[k]  = done;
      o_rdy[k] = req_ready;
      if (mutate && k == 60) drive(rnd(1'b0));
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    vectors++;
    if ({vga_x, vga_y, vga_colour, vga_write, done} !== 20'd0) begin
      miscompares++;
      $display("FAIL reset_outputs x=%0d y=%0d col=%0d wr=%b done=%b required all 0",
               vga_x, vga_y, vga_colour, vga_write, done);
    end
    resetn = 1'b1;
    @(negedge clock);
    vectors++;
    if (req_ready !== 1'b1 || vga_write !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release rdy=%b wr=%b done=%b required 1 0 0",
               req_ready, vga_write, done);
    end
  endtask

  task automatic test_basic;
    logic [2:0] ec;
    drive('{x: 8'd10, h: 7'd40, w: 3'd4, c: 3'd1, f: 3'd2});
    capture(1'b0, 1'b0);
    for (int k = 1; k <= 122; k++) begin
      ec = (k - 1 < 40) ? 3'd1 : (k - 1 < 80) ? 3'd4 : 3'd2;
      vectors++;
      if (o_dn[k] !== (k == 121) || o_rdy[k] !== (k == 122) ||
          o_wr[k] !== (k <= 120) ||
          (k <= 120 && (o_x[k] !== 8'd10 || o_y[k] !== 7'(k - 1) || o_c[k] !== ec))) begin
        miscompares++;
        $display("FAIL basic k=%0d wr=%b x=%0d y=%0d col=%0d done=%b rdy=%b required col=%0d y=%0d",
                 k, o_wr[k], o_x[k], o_y[k], o_c[k], o_dn[k], o_rdy[k], ec, k - 1);
      end
    end
  endtask

  task automatic test_heights;
    req_t r;
    bit   ew;
    for (int i = 0; i < 2; i++) begin
      r = rnd(1'b0);
      r.h = (i == 0) ? 7'd0 : 7'd127;
      drive(r);
      capture(1'b0, 1'b0);
      vectors++;
      if (o_c[61] !== ((i == 0) ? r.f : r.w) || o_c[60] !== ((i == 0) ? r.c : r.w)) begin
        miscompares++;
        $display("FAIL heights_split h=%0d y59=%0d y60=%0d required %0d %0d", r.h,
                 o_c[60], o_c[61], (i == 0) ? r.c : r.w, (i == 0) ? r.f : r.w);
      end
      for (int k = 1; k <= 122; k++) begin
        ew = (k <= 120) && (acc.x < 8'd160);
        vectors++;
        if (o_wr[k] !== ew || o_dn[k] !== (k == 121) || o_rdy[k] !== (k == 122) ||
            (ew && (o_x[k] !== acc.x || o_y[k] !== 7'(k - 1) || o_c[k] !== model(acc, k - 1)))) begin
          miscompares++;
          $display("FAIL heights k=%0d wr=%b y=%0d col=%0d done=%b rdy=%b required wr=%b col=%0d",
                   k, o_wr[k], o_y[k], o_c[k], o_dn[k], o_rdy[k], ew, model(acc, k - 1));
        end
      end
    end
  endtask

  task automatic test_odd_edge;
    int  walls;
    bit  ew;
    drive('{x: 8'd159, h: 7'd41, w: 3'd5, c: 3'd0, f: 3'd3});
    capture(1'b0, 1'b0);
    walls = 0;
    for (int k = 1; k <= 122; k++) begin
      ew = (k <= 120);
      if (ew && o_wr[k] === 1'b1 && o_c[k] === 3'd5) walls++;
      vectors++;
      if (o_wr[k] !== ew || o_dn[k] !== (k == 121) || o_rdy[k] !== (k == 122) ||
          (ew && (o_x[k] !== 8'd159 || o_y[k] !== 7'(k - 1) || o_c[k] !== model(acc, k - 1)))) begin
        miscompares++;
        $display("FAIL odd_edge k=%0d wr=%b x=%0d y=%0d col=%0d required wr=%b x=159 col=%0d",
                 k, o_wr[k], o_x[k], o_y[k], o_c[k], ew, model(acc, k - 1));
      end
    end
    vectors++;
    if (walls != 41 || o_c[40] !== 3'd5 || o_c[39] !== 3'd0 || o_c[81] !== 3'd3) begin
      miscompares++;
      $display("FAIL odd_rows walls=%0d y38=%0d y39=%0d y80=%0d required 41 0 5 3",
               walls, o_c[39], o_c[40], o_c[81]);
    end
  endtask

  task automatic test_offscreen;
    req_t r;
    int   writes;
    r = rnd(1'b0);
    r.x = 8'd200;
    drive(r);
    capture(1'b0, 1'b0);
    writes = 0;
    for (int k = 1; k <= 122; k++) begin
      if (o_wr[k] === 1'b1) writes++;
      vectors++;
      if (o_wr[k] !== 1'b0 || o_dn[k] !== (k == 121) || o_rdy[k] !== (k == 122) ||
          o_x[k] !== 8'd159 || o_y[k] !== 7'd119 || o_c[k] !== 3'd3) begin
        miscompares++;
        $display("FAIL offscreen k=%0d wr=%b x=%0d y=%0d col=%0d done=%b rdy=%b required 0 159 119 3",
                 k, o_wr[k], o_x[k], o_y[k], o_c[k], o_dn[k], o_rdy[k]);
      end
    end
    vectors++;
    if (writes != 0) begin
      miscompares++;
      $display("FAIL offscreen_writes got=%0d required 0", writes);
    end
  endtask

  task automatic test_back_to_back;
    int prev;
    bit ew;
    @(negedge clock);
    drive(rnd(1'b0));
    prev = 0;
    for (int c = 0; c < 3; c++) begin
      capture(1'b1, 1'b1);
      if (c > 0) begin
        vectors++;
        if (acc_cyc - prev != 122) begin
          miscompares++;
          $display("FAIL b2b_period got=%0d required 122", acc_cyc - prev);
        end
      end
      prev = acc_cyc;
      for (int k = 1; k <= 120; k++) begin
        ew = acc.x < 8'd160;
        vectors++;
        if (o_wr[k] !== ew || o_dn[k] !== 1'b0 || o_rdy[k] !== 1'b0 ||
            o_x[k] !== acc.x || o_y[k] !== 7'(k - 1) || o_c[k] !== model(acc, k - 1)) begin
          miscompares++;
          $display("FAIL b2b c=%0d k=%0d x=%0d y=%0d col=%0d required x=%0d col=%0d",
                   c, k, o_x[k], o_y[k], o_c[k], acc.x, model(acc, k - 1));
        end
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_random;
    bit ew;
    for (int i = 0; i < 4; i++) begin
      drive(rnd(1'b1));
      capture(1'b0, 1'b0);
      for (int k = 1; k <= 122; k++) begin
        ew = (k <= 120) && (acc.x < 8'd160);
        vectors++;
        if (o_wr[k] !== ew || o_dn[k] !== (k == 121) || o_rdy[k] !== (k == 122) ||
            (ew && (o_x[k] !== acc.x || o_y[k] !== 7'(k - 1) || o_c[k] !== model(acc, k - 1)))) begin
          miscompares++;
          $display("FAIL random i=%0d k=%0d wr=%b y=%0d col=%0d required wr=%b col=%0d",
                   i, k, o_wr[k], o_y[k], o_c[k], ew, model(acc, k - 1));
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int n;
    bit ew;
    drive(rnd(1'b0));
    req_valid = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(vga_write === 1'b1 && vga_y === 7'd50) && n < 200);
    vectors++;
    if (n >= 200) begin
      miscompares++;
      $display("FAIL reset_mid_wait y=%0d required 50", vga_y);
    end
    resetn = 1'b0;
    #1;
    vectors++;
    if (vga_write !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async wr=%b done=%b required 0 0", vga_write, done);
    end
    repeat (3) begin
      @(negedge clock);
      vectors++;
      if (vga_write !== 1'b0 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold wr=%b done=%b required 0 0", vga_write, done);
      end
    end
    resetn = 1'b1;
    @(negedge clock);
    vectors++;
    if (req_ready !== 1'b1 || done !== 1'b0 || vga_write !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_release rdy=%b done=%b wr=%b required 1 0 0",
               req_ready, done, vga_write);
    end
    drive(rnd(1'b0));
    capture(1'b0, 1'b0);
    for (int k = 1; k <= 122; k++) begin
      ew = (k <= 120);
      vectors++;
      if (o_wr[k] !== ew || o_dn[k] !== (k == 121) || o_rdy[k] !== (k == 122) ||
          (ew && (o_x[k] !== acc.x || o_y[k] !== 7'(k - 1) || o_c[k] !== model(acc, k - 1)))) begin
        miscompares++;
        $display("FAIL reset_redraw k=%0d wr=%b y=%0d col=%0d required wr=%b y=%0d col=%0d",
                 k, o_wr[k], o_y[k], o_c[k], ew, k - 1, model(acc, k - 1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_heights();
    test_odd_edge();
    test_offscreen();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
